// File: rtl/md_pkg.sv
// Shared MD-grid types and cell/offset helpers for the force writeback path.
package md_pkg;
  localparam int X_DIM     = 3;
  localparam int Y_DIM     = 3;
  localparam int Z_DIM     = 3;
  localparam int NUM_CELLS = X_DIM * Y_DIM * Z_DIM;
  localparam int CELL_ID_W = $clog2(NUM_CELLS);
  localparam int PAYLOAD_W = 32;

  localparam logic [1:0] OFF_ZERO = 2'b00;
  localparam logic [1:0] OFF_P1   = 2'b01;
  localparam logic [1:0] OFF_BAD  = 2'b10;
  localparam logic [1:0] OFF_M1   = 2'b11;

  typedef struct packed {
    logic [1:0]           off_x;
    logic [1:0]           off_y;
    logic [1:0]           off_z;
    logic [PAYLOAD_W-1:0] payload;
  } force_wb_t;

  typedef struct packed {
    logic [CELL_ID_W-1:0] dest_id;
    logic [CELL_ID_W-1:0] src_id;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  // The illegal code decodes as zero; flagging it is the caller's job.
  function automatic int dec_off(input logic [1:0] c);
    case (c)
      OFF_P1:  return 1;
      OFF_M1:  return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int wrap_coord(input int home, input logic [1:0] c, input int dim);
    int v;
    v = home + dec_off(c);
    if (v < 1) v = dim;
    else if (v > dim) v = 1;
    return v;
  endfunction

  function automatic logic [CELL_ID_W-1:0] cell_id(input int x, input int y, input int z);
    int id;
    id = (z - 1) * X_DIM * Y_DIM + (y - 1) * X_DIM + (x - 1);
    return id[CELL_ID_W-1:0];
  endfunction
endpackage

// File: rtl/force_wb_packetizer_array.sv
// One packetizer per grid cell; home coordinates follow the generate indices.
module force_wb_packetizer_array
  import md_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic      [NUM_CELLS-1:0][NUM_PORTS-1:0]      wb_valid,
  input  force_wb_t [NUM_CELLS-1:0][NUM_PORTS-1:0]      wb_in,
  output logic      [NUM_CELLS-1:0][NUM_PORTS-1:0]      wb_ready,
  output logic      [NUM_CELLS-1:0]                     pkt_valid,
  input  logic      [NUM_CELLS-1:0]                     pkt_ready,
  output packet_t   [NUM_CELLS-1:0]                     pkt_out,
  output logic      [NUM_CELLS-1:0][$clog2(FIFO_DEPTH):0] fifo_count,
  output logic      [NUM_CELLS-1:0]                     offset_err
);
  for (genvar z = 0; z < Z_DIM; z++) begin : g_z
    for (genvar y = 0; y < Y_DIM; y++) begin : g_y
      for (genvar x = 0; x < X_DIM; x++) begin : g_x
        localparam int C = (z * Y_DIM + y) * X_DIM + x;
        force_wb_packetizer #(
          .HOME_X(x + 1), .HOME_Y(y + 1), .HOME_Z(z + 1),
          .NUM_PORTS(NUM_PORTS), .FIFO_DEPTH(FIFO_DEPTH)
        ) u_cell (
          .clk       (clk),
          .rst_n     (rst_n),
          .wb_valid  (wb_valid[C]),
          .wb_in     (wb_in[C]),
          .wb_ready  (wb_ready[C]),
          .pkt_valid (pkt_valid[C]),
          .pkt_ready (pkt_ready[C]),
          .pkt_out   (pkt_out[C]),
          .fifo_count(fifo_count[C]),
          .offset_err(offset_err[C])
        );
      end
    end
  end
endmodule

// File: rtl/pkt_sync_fifo.sv
// Single-clock FIFO of packets; head is presented combinationally from memory.
module pkt_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  T                         wdata_i,
  input  logic                     rd_i,
  output logic                     rvalid_o,
  output T                         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    cnt_q;
  logic           do_rd;

  assign do_rd    = rd_i && (|cnt_q);
  assign rvalid_o = |cnt_q;
  assign rdata_o  = mem_q[rptr_q];
  assign count_o  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_i)  wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      if (wr_i && !do_rd)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!wr_i && do_rd) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/force_wb_packetizer.sv
// Round-robin merge of force writeback ports into destination-tagged ring packets.
module force_wb_packetizer
  import md_pkg::*;
#(
  parameter int HOME_X     = 1,
  parameter int HOME_Y     = 1,
  parameter int HOME_Z     = 1,
  parameter int NUM_PORTS  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic      [NUM_PORTS-1:0]     wb_valid,
  input  force_wb_t [NUM_PORTS-1:0]     wb_in,
  output logic      [NUM_PORTS-1:0]     wb_ready,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output packet_t                       pkt_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          offset_err
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CELL_ID_W-1:0] SRC_ID = cell_id(HOME_X, HOME_Y, HOME_Z);

  logic [PW-1:0] last_q, last_d, gidx, cand;
  logic          found, open_q, space, xfer, bad;
  logic          stg_vld_q, err_q;
  force_wb_t     win;
  packet_t       stg_q, stg_d;

  // Stage occupancy counts against space so the queue can never overflow.
  assign space = (int'(fifo_count) + int'(stg_vld_q)) < FIFO_DEPTH;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(last_q) + i) % NUM_PORTS);
      if (!found && wb_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    xfer     = found && open_q && space;
    wb_ready = xfer ? (NUM_PORTS'(1) << gidx) : '0;
    last_d   = xfer ? gidx : last_q;
    win      = wb_in[gidx];
    bad      = (win.off_x == OFF_BAD) || (win.off_y == OFF_BAD) || (win.off_z == OFF_BAD);
    stg_d.dest_id = cell_id(wrap_coord(HOME_X, win.off_x, X_DIM),
                            wrap_coord(HOME_Y, win.off_y, Y_DIM),
                            wrap_coord(HOME_Z, win.off_z, Z_DIM));
    stg_d.src_id  = SRC_ID;
    stg_d.payload = win.payload;
  end

  // open_q holds off acceptance for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= PW'(NUM_PORTS - 1);
      open_q    <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      open_q    <= 1'b1;
      last_q    <= last_d;
      stg_vld_q <= xfer;
      if (xfer)        stg_q <= stg_d;
      if (xfer && bad) err_q <= 1'b1;
    end
  end

  assign offset_err = err_q;

  pkt_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(packet_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (stg_vld_q),
    .wdata_i (stg_q),
    .rd_i    (pkt_ready),
    .rvalid_o(pkt_valid),
    .rdata_o (pkt_out),
    .count_o (fifo_count)
  );
endmodule

// File: tb/tb_force_wb_packetizer.sv
// Directed bench for the packetizer at home (3,1,2) on a 3x3x3 grid.
module tb_force_wb_packetizer;
  import md_pkg::*;
  localparam int NP = 2;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic      [NP-1:0]   wb_valid, wb_ready;
  force_wb_t [NP-1:0]   wb_in;
  logic                 pkt_valid, pkt_ready;
  packet_t              pkt_out;
  logic      [CW-1:0]   fifo_count;
  logic                 offset_err;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  force_wb_packetizer #(
    .HOME_X(3), .HOME_Y(1), .HOME_Z(2), .NUM_PORTS(NP), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_in(wb_in), .wb_ready(wb_ready),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_out(pkt_out),
    .fifo_count(fifo_count), .offset_err(offset_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic [1:0] ox, input logic [1:0] oy,
                       input logic [1:0] oz, input logic [31:0] pay);
    wb_in[p].off_x   = ox;
    wb_in[p].off_y   = oy;
    wb_in[p].off_z   = oz;
    wb_in[p].payload = pay;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wb_valid = '0; pkt_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wb_valid = '0; wb_in = '0; pkt_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pkt_valid", 32'(pkt_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_err", 32'(offset_err), 0);
    wb_valid = 2'b11;
    #1 chk("rst_wb_ready", 32'(wb_ready), 0);

    // wrap: (3,1,2)+(+1,-1,0) -> (1,3,2) = 15
    @(negedge clk);
    rst_n = 1'b1; wb_valid = 2'b01; pkt_ready = 1'b1;
    drive(0, 2'b01, 2'b11, 2'b00, 32'hA0);
    #1 chk("rdy_first_cycle", 32'(wb_ready), 0);
    @(negedge clk); #1 chk("wrap_grant", 32'(wb_ready), 32'h1);
    @(negedge clk); wb_valid = '0;
    #1 chk("wrap_lat", 32'(pkt_valid), 0);
    @(negedge clk); #1;
    chk("wrap_valid", 32'(pkt_valid), 1);
    chk("wrap_dest", 32'(pkt_out.dest_id), 15);
    chk("wrap_src", 32'(pkt_out.src_id), 11);
    chk("wrap_pay", pkt_out.payload, 32'hA0);
    @(negedge clk); #1 chk("wrap_drained", 32'(pkt_valid), 0);

    // fairness
    do_reset();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      pkt_ready = 1'b1;
      if (j < 6) begin
        wb_valid = 2'b11;
        drive(0, 2'b00, 2'b00, 2'b00, 32'h100 + j);
        drive(1, 2'b00, 2'b00, 2'b00, 32'h200 + j);
      end else wb_valid = '0;
      #1;
      if (j < 6) chk($sformatf("fair_grant%0d", j), 32'(wb_ready), (j % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("fair_valid%0d", j), 32'(pkt_valid), (j >= 2) ? 32'h1 : 32'h0);
      if (j >= 2) begin
        chk($sformatf("fair_pay%0d", j), pkt_out.payload,
            ((j - 2) % 2 == 0) ? 32'h100 + (j - 2) : 32'h200 + (j - 2));
        chk($sformatf("fair_dest%0d", j), 32'(pkt_out.dest_id), 11);
      end
    end

    // backpressure
    do_reset();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      wb_valid = 2'b01;
      drive(0, 2'b00, 2'b00, 2'b00, 32'h300 + j);
      #1 chk($sformatf("bp_grant%0d", j), 32'(wb_ready), (j < 4) ? 32'h1 : 32'h0);
      if (j == 2 || j == 7) chk($sformatf("bp_head%0d", j), pkt_out.payload, 32'h300);
    end
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_valid", 32'(pkt_valid), 1);
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      wb_valid = '0; pkt_ready = 1'b1;
      #1;
      chk($sformatf("bp_drain_v%0d", d), 32'(pkt_valid), 1);
      chk($sformatf("bp_drain_p%0d", d), pkt_out.payload, 32'h300 + d);
    end
    @(negedge clk); #1;
    chk("bp_empty", 32'(pkt_valid), 0);
    chk("bp_empty_cnt", 32'(fifo_count), 0);

    // illegal offset
    do_reset();
    @(negedge clk);
    pkt_ready = 1'b1; wb_valid = 2'b01;
    drive(0, 2'b10, 2'b00, 2'b00, 32'h400);
    #1 chk("ill_err_pre", 32'(offset_err), 0);
    @(negedge clk); wb_valid = '0;
    #1 chk("ill_err_set", 32'(offset_err), 1);
    @(negedge clk); #1;
    chk("ill_valid", 32'(pkt_valid), 1);
    chk("ill_dest", 32'(pkt_out.dest_id), 11);
    chk("ill_src", 32'(pkt_out.src_id), 11);
    chk("ill_pay", pkt_out.payload, 32'h400);
    repeat (3) @(negedge clk);
    #1 chk("ill_err_hold", 32'(offset_err), 1);

    // reset with entries queued
    do_reset();
    #1 chk("rm_err_clr", 32'(offset_err), 0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      pkt_ready = 1'b0;
      wb_valid = (j < 3) ? 2'b01 : 2'b00;
      drive(0, 2'b00, 2'b00, 2'b00, 32'h500 + j);
    end
    #1 chk("rm_count_pre", 32'(fifo_count), 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_valid", 32'(pkt_valid), 0);
    chk("rm_count", 32'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1; pkt_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      #1 chk($sformatf("rm_quiet%0d", j), 32'(pkt_valid), 0);
    end

    // simultaneous pop and write at count 3
    do_reset();
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      wb_valid = (j < 4) ? 2'b01 : 2'b00;
      drive(0, 2'b00, 2'b00, 2'b00, 32'h600 + j);
      pkt_ready = (j >= 4);
      #1;
      if (j == 3) chk("pw_grant3", 32'(wb_ready), 32'h1);
      if (j == 4 || j == 5) chk($sformatf("pw_count%0d", j), 32'(fifo_count), 3);
      if (j >= 4 && j < 8) chk($sformatf("pw_pay%0d", j), pkt_out.payload, 32'h600 + (j - 4));
      if (j == 8) chk("pw_empty", 32'(pkt_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/force_wb_packetizer.md
FORCE_WB_PACKETIZER -- requirements
Module: force_wb_packetizer

Interface
REQ-001 Parameter HOME_X, default 1, home cell X coordinate (1-based).
REQ-002 Parameter HOME_Y, default 1, home cell Y coordinate (1-based).
REQ-003 Parameter HOME_Z, default 1, home cell Z coordinate (1-based).
REQ-004 Parameter NUM_PORTS, default 2, number of force-pipeline writeback ports; legal range 1..8.
REQ-005 Parameter FIFO_DEPTH, default 8, output queue entries; power of two, at least 2.
REQ-006 clk  input  1  single clock; all state on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 wb_valid  input  NUM_PORTS  per-port writeback request.
REQ-009 wb_in  input  NUM_PORTS x force_wb_t  per-port writeback: 2-bit offsets off_x, off_y, off_z, plus force payload.
REQ-010 wb_ready  output  NUM_PORTS  per-port accept; transfer occurs when wb_valid[i] and wb_ready[i] are both high.
REQ-011 pkt_valid  output  1  head packet available to the ring.
REQ-012 pkt_ready  input  1  ring accepts the head packet.
REQ-013 pkt_out  output  packet_t  dest_id, src_id, payload.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied queue entries.
REQ-015 offset_err  output  1  sticky flag; set on any accepted illegal offset code.

Function
REQ-016 The offset code SHALL decode as follows: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, and 2'b10 = illegal (treated as 0, sets offset_err).
REQ-017 Each destination coordinate SHALL equal the home coordinate plus the offset, with periodic wrap: 0 maps to DIM and DIM+1 maps to 1.
REQ-018 The output SHALL be computed as dest_id = (z-1)*X_DIM*Y_DIM + (y-1)*X_DIM + (x-1); src_id is the same formula applied to the home coordinates.
REQ-019 At most one wb_ready bit SHALL be high per cycle, and it SHALL go only to the round-robin winner among the asserted wb_valid ports.
REQ-020 Round-robin priority SHALL start at the port above the last granted port, with wrap; after reset the last granted port is NUM_PORTS-1, so port 0 has first priority.
REQ-021 The last-granted pointer SHALL update only on an actual transfer.
REQ-022 wb_ready SHALL be asserted only when fifo_count plus the stage-register valid is less than FIFO_DEPTH, so no write ever reaches a full queue.
REQ-023 A transfer accepted in cycle N SHALL be captured in the mapping stage register at edge N+1 and written into the queue at edge N+2; pkt_valid is visible from cycle N+2 at the earliest.
REQ-024 The queue SHALL be FIFO-ordered, and pkt_out SHALL be stable while pkt_valid is high and pkt_ready is low.
REQ-025 On a simultaneous queue write and pop, fifo_count SHALL stay unchanged; the ready decision uses the pre-pop count.
REQ-026 When the queue is empty, pkt_valid SHALL be 0 and pkt_out is don't-care.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 With NUM_PORTS=1, the block SHALL pass through the single port with no arbitration penalty.

Reset
REQ-029 When rst_n is low, the block SHALL immediately clear: pkt_valid=0, wb_ready=0, fifo_count=0, offset_err=0, pointers=0, stage-register valid=0, last-grant=NUM_PORTS-1.
REQ-030 A reset asserted mid-operation SHALL discard all queued and in-stage packets without emitting them.
REQ-031 wb_ready SHALL stay 0 during the first cycle after rst_n deasserts.

Structure
REQ-032 force_wb_t, packet_t, X_DIM, Y_DIM, Z_DIM, and NUM_CELLS SHALL live in md_pkg, together with a new CELL_ID_W constant and offset-code localparams.
REQ-033 The queue SHALL be a separate sub-module, pkt_sync_fifo, parameterised by depth and packet type.
REQ-034 Arbitration, decode, and wrap SHALL reside in the top module.
REQ-035 A wrapper SHALL instantiate one force_wb_packetizer per cell with the home coordinates derived from the loop indices.

Verification (X_DIM=Y_DIM=Z_DIM=3, HOME=(3,1,2), NUM_PORTS=2, FIFO_DEPTH=4)
REQ-036 Wrap case: port 0 sends off=(+1,-1,0) with pkt_ready=1 -> pkt_valid two cycles later with dest_id=15 and src_id=11.
REQ-037 Fairness: both ports valid for 6 cycles with pkt_ready=1 -> grants alternate 0,1,0,1,0,1 and packets emerge in that order.
REQ-038 Backpressure: pkt_ready=0 with continuous valid -> 4 packets are accepted, fifo_count=4, wb_ready=0, and pkt_out holds; raising pkt_ready drains all 4 in order.
REQ-039 Illegal offset: off_x=2'b10 with others 0 -> dest_id=src_id=11 and offset_err=1, held until reset.
REQ-040 Reset with 3 entries queued -> pkt_valid=0 and fifo_count=0 immediately; after release nothing is emitted without new input.
REQ-041 Simultaneous pop and write at fifo_count=3 -> fifo_count stays 3 and ordering is preserved.
